// File: rtl/noise_video_gen.sv
// noise_video_gen: divided pixel timing with a 16-bit LFSR luma source.
// Frame mode (PAL / line-doubled) is frozen at each frame wrap.
module noise_video_gen (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic [7:0] video
);

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [8:0]  H_LAST = 9'd399;

  logic [1:0]  div_q, div_d;
  logic        ce_q, ce_d;
  logic        first_q;
  logic        pal_q, pal_d;
  logic        dbl_q, dbl_d;
  logic [8:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] seed_q, seed_d;
  logic [15:0] src;
  logic        hb_q, hb_d, hs_q, hs_d;
  logic        vb_q, vb_d, vs_q, vs_d;
  logic [7:0]  vid_q, vid_d;
  logic [9:0]  v_last, vb_start;
  logic [9:0]  vs_start, vs_end;
  logic        line_end, frame_end;
  logic        restore, act_d;

  always_comb begin
    div_d     = div_q + 2'd1;
    line_end  = ce_q && (hc_q == H_LAST);
    unique case ({pal_q, dbl_q})
      2'b00: v_last = 10'd261;
      2'b10: v_last = 10'd311;
      2'b01: v_last = 10'd523;
      2'b11: v_last = 10'd623;
    endcase
    frame_end = line_end && (vc_q >= v_last);

    pal_d = pal_q;
    dbl_d = dbl_q;
    if (first_q || frame_end) begin
      pal_d = pal;
      dbl_d = scandouble;
    end
    ce_d = dbl_d ? div_d[0] : (div_d == 2'd3);

    hc_d = hc_q;
    vc_d = vc_q;
    if (ce_q)
      hc_d = line_end ? 9'd0 : hc_q + 9'd1;
    if (line_end)
      vc_d = frame_end ? 10'd0 : vc_q + 10'd1;

    vb_start = dbl_d ? 10'd480 : 10'd240;
    unique case ({pal_d, dbl_d})
      2'b00: begin vs_start = 10'd244; vs_end = 10'd246; end
      2'b10: begin vs_start = 10'd270; vs_end = 10'd272; end
      2'b01: begin vs_start = 10'd488; vs_end = 10'd493; end
      2'b11: begin vs_start = 10'd540; vs_end = 10'd545; end
    endcase

    hb_d = hb_q;
    hs_d = hs_q;
    vb_d = vb_q;
    vs_d = vs_q;
    if (ce_q) begin
      hb_d = (hc_d >= 9'd320);
      hs_d = (hc_d >= 9'd336) && (hc_d <= 9'd367);
      vb_d = (vc_d >= vb_start);
      vs_d = (vc_d >= vs_start) && (vc_d <= vs_end);
    end
    act_d = (hc_d < 9'd320) && (vc_d < vb_start);

    // odd doubled line replays the noise saved at its even twin
    restore = line_end && dbl_d && vc_d[0];
    src     = restore ? seed_q : lfsr_q;
    seed_d  = seed_q;
    if (line_end && !restore)
      seed_d = lfsr_q;

    lfsr_d = lfsr_q;
    vid_d  = vid_q;
    if (ce_q) begin
      vid_d  = 8'h00;
      lfsr_d = src;
      if (src == 16'h0000) begin
        lfsr_d = SEED;
      end else if (act_d) begin
        vid_d  = src[7:0];
        lfsr_d = {src[14:0], src[15] ^ src[13] ^ src[12] ^ src[10]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= 2'd0;
      ce_q    <= 1'b0;
      first_q <= 1'b1;
      pal_q   <= 1'b0;
      dbl_q   <= 1'b0;
      hc_q    <= 9'd0;
      vc_q    <= 10'd0;
      lfsr_q  <= SEED;
      seed_q  <= SEED;
      hb_q    <= 1'b0;
      hs_q    <= 1'b0;
      vb_q    <= 1'b0;
      vs_q    <= 1'b0;
      vid_q   <= 8'h00;
    end else begin
      div_q   <= div_d;
      ce_q    <= ce_d;
      first_q <= 1'b0;
      pal_q   <= pal_d;
      dbl_q   <= dbl_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      hb_q    <= hb_d;
      hs_q    <= hs_d;
      vb_q    <= vb_d;
      vs_q    <= vs_d;
      vid_q   <= vid_d;
    end
  end

  assign ce_pix = ce_q;
  assign HBlank = hb_q;
  assign HSync  = hs_q;
  assign VBlank = vb_q;
  assign VSync  = vs_q;
  assign video  = vid_q;

endmodule

// File: tb/tb_noise_video_gen.sv
// tb_noise_video_gen: directed scenarios for noise_video_gen.
// Long frames are shortened by forcing the counters near line ends.
module tb_noise_video_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pal = 1'b0;
  logic       scandouble = 1'b0;
  logic       ce_pix, HBlank, HSync, VBlank, VSync;
  logic [7:0] video;

  logic [8:0]  jh;
  logic [9:0]  jv;
  logic [15:0] jl;

  int n_chk = 0;
  int n_pass = 0;

  noise_video_gen dut (
    .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
    .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync),
    .VBlank(VBlank), .VSync(VSync), .video(video)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nx(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance through the next ce_pix edge
  task automatic pix();
    int n = 0;
    while (ce_pix !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    tick();
  endtask

  // set hc/vc/lfsr across one non-pixel edge; call right after pix()
  task automatic jump(input logic [8:0] h, input logic [9:0] v,
                      input logic [15:0] l);
    jh = h;
    jv = v;
    jl = l;
    force dut.hc_q = jh;
    force dut.vc_q = jv;
    force dut.lfsr_q = jl;
    tick();
    release dut.hc_q;
    release dut.vc_q;
    release dut.lfsr_q;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({ce_pix, HBlank, HSync, VBlank, VSync, video} !== 13'd0)
      $display("FAIL reset_hold: got %b_%b%b%b%b_%h, want all 0",
               ce_pix, HBlank, HSync, VBlank, VSync, video);
    else n_pass++;
  endtask

  task automatic test_ntsc_line();
    int k = 0;
    int h;
    int hs_n = 0;
    logic [15:0] m = SEED;
    logic [3:0] ef;
    logic [7:0] ev;
    @(negedge clk);
    reset_n = 1'b1;
    do begin tick(); k++; end while (ce_pix !== 1'b1 && k < 10);
    n_chk++;
    if (k !== 3) $display("FAIL first_ce: ce after edge %0d, want 3", k);
    else n_pass++;
    k = 0;
    do begin tick(); k++; end while (ce_pix !== 1'b1 && k < 10);
    n_chk++;
    if (k !== 4) $display("FAIL ce_period: got %0d clk, want 4", k);
    else n_pass++;
    for (int s = 1; s <= 405; s++) begin
      if (s > 1) pix();
      h = s % 400;
      ef = {h >= 320, (h >= 336) && (h <= 367), 2'b00};
      ev = 8'h00;
      if (h < 320) begin
        ev = m[7:0];
        m = nx(m);
      end
      if (HSync === 1'b1) hs_n++;
      n_chk++;
      if ({HBlank, HSync, VBlank, VSync} !== ef || video !== ev)
        $display("FAIL line0 s=%0d: flags=%b video=%h, want flags=%b video=%h",
                 s, {HBlank, HSync, VBlank, VSync}, video, ef, ev);
      else n_pass++;
    end
    n_chk++;
    if (hs_n !== 32) $display("FAIL hsync_width: got %0d, want 32", hs_n);
    else n_pass++;
  endtask

  task automatic test_ntsc_vert();
    logic [9:0] vp [8] = '{10'd238, 10'd239, 10'd243, 10'd245,
                           10'd246, 10'd260, 10'd261, 10'd290};
    logic [1:0] ex [8] = '{2'b00, 2'b10, 2'b11, 2'b11,
                           2'b10, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      jump(9'd398, vp[i], SEED);
      pix();
      pix();
      n_chk++;
      if ({HBlank, HSync, VBlank, VSync} !== {2'b00, ex[i]})
        $display("FAIL ntsc_vert after vc=%0d: flags=%b, want %b",
                 vp[i], {HBlank, HSync, VBlank, VSync}, {2'b00, ex[i]});
      else n_pass++;
    end
  endtask

  task automatic test_pal_switch();
    logic [9:0] vp [11] = '{10'd243, 10'd260, 10'd261, 10'd239,
                            10'd243, 10'd269, 10'd271, 10'd272,
                            10'd261, 10'd310, 10'd311};
    logic [1:0] ex [11] = '{2'b11, 2'b10, 2'b00, 2'b10,
                            2'b10, 2'b11, 2'b11, 2'b10,
                            2'b10, 2'b10, 2'b00};
    jump(9'd398, 10'd99, SEED);
    pix();
    pix();
    pal = 1'b1;
    for (int i = 0; i < 11; i++) begin
      jump(9'd398, vp[i], SEED);
      pix();
      pix();
      n_chk++;
      if ({HBlank, HSync, VBlank, VSync} !== {2'b00, ex[i]})
        $display("FAIL pal_switch row %0d after vc=%0d: flags=%b, want %b",
                 i, vp[i], {HBlank, HSync, VBlank, VSync}, {2'b00, ex[i]});
      else n_pass++;
    end
  endtask

  task automatic test_scandouble();
    int p;
    int h;
    logic [15:0] m;
    logic [7:0] ev;
    logic [9:0] vp [8] = '{10'd479, 10'd487, 10'd492, 10'd493,
                           10'd243, 10'd261, 10'd522, 10'd523};
    logic [1:0] ex [8] = '{2'b10, 2'b11, 2'b11, 2'b10,
                           2'b00, 2'b00, 2'b10, 2'b00};
    pal = 1'b0;
    scandouble = 1'b1;
    jump(9'd398, 10'd311, SEED);
    pix();
    pix();
    p = 0;
    while (ce_pix !== 1'b1 && p < 10) begin tick(); p++; end
    tick();
    p = 1;
    while (ce_pix !== 1'b1 && p < 10) begin tick(); p++; end
    n_chk++;
    if (p !== 2) $display("FAIL dbl_ce_period: got %0d clk, want 2", p);
    else n_pass++;
    pix();
    for (int i = 0; i < 8; i++) begin
      jump(9'd398, vp[i], SEED);
      pix();
      pix();
      n_chk++;
      if ({HBlank, HSync, VBlank, VSync} !== {2'b00, ex[i]})
        $display("FAIL dbl_vert after vc=%0d: flags=%b, want %b",
                 vp[i], {HBlank, HSync, VBlank, VSync}, {2'b00, ex[i]});
      else n_pass++;
    end
    jump(9'd398, 10'd9, 16'h1234);
    pix();
    m = 16'h1234;
    for (int i = 0; i < 800; i++) begin
      pix();
      h = i % 400;
      if (i == 400) m = 16'h1234;
      ev = 8'h00;
      if (h < 320) begin
        ev = m[7:0];
        m = nx(m);
      end
      n_chk++;
      if (video !== ev)
        $display("FAIL dbl_line vc=%0d hc=%0d: video=%h, want %h",
                 10 + i / 400, h, video, ev);
      else n_pass++;
    end
  endtask

  task automatic test_lfsr_zero();
    logic [15:0] s1;
    logic [7:0] ev [3];
    s1 = nx(SEED);
    ev[0] = 8'h00;
    ev[1] = SEED[7:0];
    ev[2] = s1[7:0];
    jump(9'd98, 10'd20, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      pix();
      n_chk++;
      if (video !== ev[i])
        $display("FAIL lfsr_zero pixel %0d: video=%h, want %h", i, video, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_restart();
    int k = 0;
    logic [15:0] m = SEED;
    scandouble = 1'b0;
    jump(9'd398, 10'd523, SEED);
    pix();
    pix();
    jump(9'd349, 10'd245, SEED);
    pix();
    n_chk++;
    if ({HBlank, HSync, VBlank, VSync, video} !== {4'b1111, 8'h00})
      $display("FAIL pre_reset hc=350 vc=245: flags=%b video=%h, want 1111 00",
               {HBlank, HSync, VBlank, VSync}, video);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ce_pix, HBlank, HSync, VBlank, VSync, video} !== 13'd0)
      $display("FAIL async_reset: got %b_%b%b%b%b_%h, want all 0",
               ce_pix, HBlank, HSync, VBlank, VSync, video);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    do begin tick(); k++; end while (ce_pix !== 1'b1 && k < 10);
    n_chk++;
    if (k !== 3) $display("FAIL restart_first_ce: edge %0d, want 3", k);
    else n_pass++;
    k = 0;
    do begin tick(); k++; end while (ce_pix !== 1'b1 && k < 10);
    n_chk++;
    if (k !== 4) $display("FAIL restart_ce_period: got %0d, want 4", k);
    else n_pass++;
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) pix();
      n_chk++;
      if ({HBlank, HSync, VBlank, VSync} !== 4'b0000 || video !== m[7:0])
        $display("FAIL restart s=%0d: flags=%b video=%h, want 0000 %h",
                 s, {HBlank, HSync, VBlank, VSync}, video, m[7:0]);
      else n_pass++;
      m = nx(m);
    end
  endtask

  initial begin
    test_reset();
    test_ntsc_line();
    test_ntsc_vert();
    test_pal_switch();
    test_scandouble();
    test_lfsr_zero();
    test_reset_restart();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
